qspi_sram_responder: RTL and testbench
======================================

// Module: qspi_sram_responder
// PURPOSE
//  Synthesizable QSPI (SQI-mode) serial-SRAM target: the device end of the bus that the core's QSPI_SRAM master drives.
//  Oversamples CS_N/SCK/SIO in the CLK domain, decodes READ/WRITE transactions and serves them from an internal byte array.
//  Used as the on-FPGA/bench stand-in for the external serial SRAM so that the core can run without the real chip.
// PARAMETERS
//  ADDR_W     16     transaction address width in bits (always 4 nibbles on the bus)
//  MEM_DEPTH  4096   bytes of storage; the effective address is addr % MEM_DEPTH (MEM_DEPTH must be a power of 2)
//  CMD_READ   8'h03  read opcode
//  CMD_WRITE  8'h02  write opcode
// PORTS
//  CLK          in   1  system clock; all logic is on its rising edge
//  RES          in   1  synchronous reset, active-high
//  QSPI_CS_N    in   1  chip select from the master, active-low
//  QSPI_SCK     in   1  serial clock from the master; frequency <= CLK/4
//  QSPI_SIO_I   in   4  nibble driven by the master
//  QSPI_SIO_O   out  4  nibble driven by this target
//  QSPI_SIO_E   out  4  output enable per lane (1 = drive)
//  BUSY         out  1  1 while CS_N is sampled low
//  CMD_ERR      out  1  1-CLK pulse when an opcode other than READ/WRITE is received
// BEHAVIOUR
//  Input sync: CS_N, SCK and SIO each pass through 2 FFs. rise = sck_s1 & ~sck_s2; fall = ~sck_s1 & sck_s2. SIO is sampled on rise.
//  Nibble order: MSB nibble first. Opcode = 2 nibbles, address = 4 nibbles (MSB first), data = 2 nibbles per byte.
//  FSM: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
//   IDLE   : synced CS_N falls -> CMD with nib_cnt=0.
//   CMD    : 2 rises; then ==CMD_READ -> ADDR(rd), ==CMD_WRITE -> ADDR(wr), other -> IGNORE and pulse CMD_ERR.
//   ADDR   : 4 rises load addr[15:0]; read -> DUMMY, write -> WDATA.
//   DUMMY  : 2 rises (one dummy byte); the shift register is loaded with mem[addr] at the 2nd rise -> RDATA.
//   RDATA  : on each fall, drive the next nibble (high, then low); after the low nibble is driven, addr++ and mem[addr] is prefetched.
//   WDATA  : high nibble captured on rise #1, byte written on rise #2, then addr++.
//   IGNORE : no driving and no writes until CS_N rises.
//  Synced CS_N high in any state -> IDLE on the next CLK. nib_cnt is cleared, SIO_E=0 and no write is issued.
//   A write byte with only one nibble received is discarded.
//  Address increments are modulo 2^ADDR_W. The array index is addr[log2(MEM_DEPTH)-1:0], so reads and writes wrap.
//  SIO_E = 4'hF only in RDATA, from the first fall after the 2nd dummy rise until CS_N rises; otherwise 4'h0.
//   SIO_O holds its last value when SIO_E=0.
//  Read latency: the first data nibble is valid on the bus no later than 3 CLK after the SCK fall (sync plus output register).
//   This meets the master's next-rise sample because SCK <= CLK/4.
//  Simultaneous SCK rise and CS_N rise in the same CLK: CS_N wins; the nibble is ignored.
//  Reset values: SIO_O=0, SIO_E=0, BUSY=0, CMD_ERR=0, FSM=IDLE, counters=0. Memory contents are NOT cleared by RES.
//  RES asserted mid-transaction: the next CLK is IDLE and outputs are at reset values. A partial write byte is lost.
//   Completed bytes remain stored.
//  A single write port and a single read port on the array make it map to block RAM. Reads are registered (1 CLK).
// TESTING
//  1 Reset: hold RES 2 CLK with CS_N=1 -> SIO_E=0, SIO_O=0, BUSY=0, CMD_ERR=0.
//  2 Write then read: WRITE addr 16'h0010 with data 8'hA5, CS_N high; READ 16'h0010 with 1 dummy byte.
//     -> SIO_E=F during data; nibbles 4'hA, 4'h5; master reads 8'hA5.
//  3 Burst: WRITE 16'h0FFE with bytes 11,22,33,44 (MEM_DEPTH=4096).
//     -> READ 16'h0FFE returns 11,22,33,44; READ 16'h0000 returns 33.
//  4 Partial write: WRITE 16'h0020, send one nibble 4'hC, raise CS_N.
//     -> mem[0x20] unchanged; the next transaction decodes normally.
//  5 Bad opcode 8'h9F: CMD_ERR pulses for 1 CLK and SIO_E stays 0 for the rest of the frame.
//     -> A following READ works.
//  6 Reset mid-read: assert RES during RDATA.
//     -> SIO_E=0 on the next CLK; after release, a READ of the same address returns the original data.
//  All scenarios run at SCK = CLK/4 and CLK/8, and also against the QSPI_SRAM master instance in a loopback bench.

Source files
------------

// File: rtl/qspi_sram_responder.sv
// QSPI (SQI-mode) serial-SRAM target: oversamples the master's CS_N/SCK/SIO in the CLK domain
// and serves READ/WRITE transactions from an internal block-RAM byte array.
module qspi_sram_responder #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       QSPI_CS_N,
  input  logic       QSPI_SCK,
  input  logic [3:0] QSPI_SIO_I,
  output logic [3:0] QSPI_SIO_O,
  output logic [3:0] QSPI_SIO_E,
  output logic       BUSY,
  output logic       CMD_ERR
);

  localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
  localparam int unsigned ADDR_NIBS = ADDR_W / 4;
  localparam int unsigned CNT_W     = $clog2(ADDR_NIBS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    nib_cnt, nib_cnt_d;
  logic                is_rd, is_rd_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [3:0]          hi_nib, hi_nib_d;
  logic [7:0]          shreg, shreg_d;
  logic [1:0]          pf, pf_d;
  logic [3:0]          sio_o_d, sio_e_d;
  logic                cmd_err_d;
  logic                mem_we_c;
  logic [7:0]          wdata_c;
  logic [7:0]          rdata;
  logic [7:0]          mem [MEM_DEPTH];

  logic       csl_s1, csl_s2, sck_s1, sck_s2;
  logic [3:0] sio_s1, sio_s2;
  logic       rise, fall;

  // Two-flop synchronizers; CS_N is kept inverted so BUSY comes straight off a flop
  always_ff @(posedge CLK) begin
    if (RES) begin
      csl_s1 <= 1'b0;
      csl_s2 <= 1'b0;
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sio_s1 <= 4'h0;
      sio_s2 <= 4'h0;
    end else begin
      csl_s1 <= ~QSPI_CS_N;
      csl_s2 <= csl_s1;
      sck_s1 <= QSPI_SCK;
      sck_s2 <= sck_s1;
      sio_s1 <= QSPI_SIO_I;
      sio_s2 <= sio_s1;
    end
  end

  assign rise = sck_s1 & ~sck_s2;
  assign fall = ~sck_s1 & sck_s2;
  assign BUSY = csl_s2;

  // Next-state and datapath decode
  always_comb begin
    state_d   = state;
    nib_cnt_d = nib_cnt;
    is_rd_d   = is_rd;
    addr_d    = addr;
    hi_nib_d  = hi_nib;
    shreg_d   = shreg;
    pf_d      = {pf[0], 1'b0};
    sio_o_d   = QSPI_SIO_O;
    sio_e_d   = QSPI_SIO_E;
    cmd_err_d = 1'b0;
    mem_we_c  = 1'b0;
    wdata_c   = 8'h00;

    if (pf[1]) shreg_d = rdata;

    if (!csl_s2) begin
      // Deselect beats any same-cycle SCK edge
      state_d   = S_IDLE;
      nib_cnt_d = '0;
      sio_e_d   = 4'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_d   = S_CMD;
          nib_cnt_d = '0;
          sio_e_d   = 4'h0;
        end
        S_CMD: if (rise) begin
          if (nib_cnt == '0) begin
            hi_nib_d  = sio_s2;
            nib_cnt_d = CNT_W'(1);
          end else begin
            nib_cnt_d = '0;
            if ({hi_nib, sio_s2} == CMD_READ) begin
              is_rd_d = 1'b1;
              state_d = S_ADDR;
            end else if ({hi_nib, sio_s2} == CMD_WRITE) begin
              is_rd_d = 1'b0;
              state_d = S_ADDR;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = S_IGNORE;
            end
          end
        end
        S_ADDR: if (rise) begin
          addr_d = {addr[ADDR_W-5:0], sio_s2};
          if (nib_cnt == CNT_W'(ADDR_NIBS - 1)) begin
            nib_cnt_d = '0;
            state_d   = is_rd ? S_DUMMY : S_WDATA;
          end else begin
            nib_cnt_d = nib_cnt + CNT_W'(1);
          end
        end
        S_DUMMY: if (rise) begin
          if (nib_cnt == '0) begin
            nib_cnt_d = CNT_W'(1);
          end else begin
            nib_cnt_d = '0;
            shreg_d   = rdata;
            state_d   = S_RDATA;
          end
        end
        S_RDATA: if (fall) begin
          sio_e_d = 4'hF;
          if (nib_cnt == '0) begin
            sio_o_d   = shreg[7:4];
            nib_cnt_d = CNT_W'(1);
          end else begin
            // Low nibble out: step the address and refill shreg once the RAM catches up
            sio_o_d   = shreg[3:0];
            nib_cnt_d = '0;
            addr_d    = addr + ADDR_W'(1);
            pf_d[0]   = 1'b1;
          end
        end
        S_WDATA: if (rise) begin
          if (nib_cnt == '0) begin
            hi_nib_d  = sio_s2;
            nib_cnt_d = CNT_W'(1);
          end else begin
            mem_we_c  = 1'b1;
            wdata_c   = {hi_nib, sio_s2};
            addr_d    = addr + ADDR_W'(1);
            nib_cnt_d = '0;
          end
        end
        S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RES) begin
      state      <= S_IDLE;
      nib_cnt    <= '0;
      is_rd      <= 1'b0;
      addr       <= '0;
      hi_nib     <= 4'h0;
      shreg      <= 8'h00;
      pf         <= 2'b00;
      QSPI_SIO_O <= 4'h0;
      QSPI_SIO_E <= 4'h0;
      CMD_ERR    <= 1'b0;
    end else begin
      state      <= state_d;
      nib_cnt    <= nib_cnt_d;
      is_rd      <= is_rd_d;
      addr       <= addr_d;
      hi_nib     <= hi_nib_d;
      shreg      <= shreg_d;
      pf         <= pf_d;
      QSPI_SIO_O <= sio_o_d;
      QSPI_SIO_E <= sio_e_d;
      CMD_ERR    <= cmd_err_d;
    end
  end

  // One write port, one registered read port; contents survive reset
  always_ff @(posedge CLK) begin
    if (mem_we_c) mem[addr[MEM_AW-1:0]] <= wdata_c;
    rdata <= mem[addr[MEM_AW-1:0]];
  end

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Bench for qspi_sram_responder: acts as the QSPI master at SCK = CLK/4 and CLK/8, runs a
// directed transaction table, hand-written reset/deselect sequences and random traffic vs. a byte-array model.
module tb_qspi_sram_responder;

  logic       CLK = 1'b0;
  logic       RES;
  logic       QSPI_CS_N;
  logic       QSPI_SCK;
  logic [3:0] QSPI_SIO_I;
  logic [3:0] QSPI_SIO_O;
  logic [3:0] QSPI_SIO_E;
  logic       BUSY;
  logic       CMD_ERR;

  qspi_sram_responder dut (
    .CLK        (CLK),
    .RES        (RES),
    .QSPI_CS_N  (QSPI_CS_N),
    .QSPI_SCK   (QSPI_SCK),
    .QSPI_SIO_I (QSPI_SIO_I),
    .QSPI_SIO_O (QSPI_SIO_O),
    .QSPI_SIO_E (QSPI_SIO_E),
    .BUSY       (BUSY),
    .CMD_ERR    (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_PART = 2;
  localparam int K_BAD  = 3;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    int          n;
    logic [31:0] data;   // right-aligned bytes, first byte on the bus is most significant
  } vec_t;

  int hp;
  int vecs = 0;
  int miss = 0;
  int err_cycles = 0;
  int oe_cycles  = 0;

  logic [7:0] mdl [4096];
  bit         vld [4096];
  logic [15:0] wq[$];

  always @(negedge CLK) begin
    if (CMD_ERR === 1'b1) err_cycles++;
    if (QSPI_SIO_E !== 4'h0) oe_cycles++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s (hp=%0d): got %0h expected %0h", nm, hp, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_nib(input logic [3:0] d);
    QSPI_SIO_I = d;
    clks(hp);
    QSPI_SCK = 1'b1;
    clks(hp);
    QSPI_SCK = 1'b0;
  endtask

  task automatic recv_nib(output logic [3:0] q, output logic [3:0] e);
    clks(hp);
    q = QSPI_SIO_O;
    e = QSPI_SIO_E;
    QSPI_SCK = 1'b1;
    clks(hp);
    QSPI_SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic begin_frame();
    QSPI_CS_N = 1'b0;
    clks(3);
  endtask

  task automatic end_frame();
    clks(hp);
    QSPI_CS_N = 1'b1;
    clks(4);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [15:0] a);
    send_byte(op);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic do_write(input logic [15:0] a, input int n, input logic [31:0] d);
    begin_frame();
    hdr(8'h02, a);
    for (int i = 0; i < n; i++) send_byte(d[8*(n-1-i) +: 8]);
    end_frame();
  endtask

  task automatic do_read(input logic [15:0] a, input int n, output logic [31:0] got, output logic oe_ok);
    logic [3:0] qh, ql, eh, el;
    got   = '0;
    oe_ok = 1'b1;
    begin_frame();
    hdr(8'h03, a);
    send_byte(8'h00);
    for (int i = 0; i < n; i++) begin
      recv_nib(qh, eh);
      recv_nib(ql, el);
      got = {got[23:0], qh, ql};
      if (eh !== 4'hF || el !== 4'hF) oe_ok = 1'b0;
    end
    end_frame();
  endtask

  initial begin
    vec_t        tbl [13];
    logic [31:0] got, exp;
    logic        oe_ok;
    logic [3:0]  q, e;
    int          e0, r0, k, n;
    logic [15:0] a, ai;
    logic [31:0] d;

    tbl[0]  = '{K_WR,   16'h0010, 1, 32'h0000_00A5};
    tbl[1]  = '{K_RD,   16'h0010, 1, 32'h0000_00A5};
    tbl[2]  = '{K_WR,   16'h0FFE, 4, 32'h1122_3344};
    tbl[3]  = '{K_RD,   16'h0FFE, 4, 32'h1122_3344};
    tbl[4]  = '{K_RD,   16'h0000, 1, 32'h0000_0033};
    tbl[5]  = '{K_WR,   16'h0020, 1, 32'h0000_005A};
    tbl[6]  = '{K_PART, 16'h0020, 1, 32'h0000_000C};
    tbl[7]  = '{K_RD,   16'h0020, 1, 32'h0000_005A};
    tbl[8]  = '{K_BAD,  16'h0000, 0, 32'h0000_009F};
    tbl[9]  = '{K_RD,   16'h0FFF, 2, 32'h0000_2233};
    tbl[10] = '{K_WR,   16'hFFFF, 2, 32'h0000_BEEF};
    tbl[11] = '{K_RD,   16'h0FFF, 2, 32'h0000_BEEF};
    tbl[12] = '{K_RD,   16'hF000, 1, 32'h0000_00EF};

    hp         = 2;
    RES        = 1'b1;
    QSPI_CS_N  = 1'b1;
    QSPI_SCK   = 1'b0;
    QSPI_SIO_I = 4'h0;
    clks(2);
    chk("rst_sio_e",   32'(QSPI_SIO_E), 32'h0);
    chk("rst_sio_o",   32'(QSPI_SIO_O), 32'h0);
    chk("rst_busy",    32'(BUSY),       32'h0);
    chk("rst_cmd_err", 32'(CMD_ERR),    32'h0);
    RES = 1'b0;
    clks(3);

    for (int sp = 0; sp < 2; sp++) begin
      hp = (sp == 0) ? 2 : 4;

      foreach (tbl[i]) begin
        case (tbl[i].kind)
          K_WR: do_write(tbl[i].addr, tbl[i].n, tbl[i].data);
          K_RD: begin
            do_read(tbl[i].addr, tbl[i].n, got, oe_ok);
            chk($sformatf("tbl%0d_data", i), got, tbl[i].data);
            chk($sformatf("tbl%0d_oe", i), 32'(oe_ok), 32'h1);
          end
          K_PART: begin
            begin_frame();
            hdr(8'h02, tbl[i].addr);
            send_nib(tbl[i].data[3:0]);
            end_frame();
          end
          default: begin
            e0 = oe_cycles;
            r0 = err_cycles;
            begin_frame();
            hdr(tbl[i].data[7:0], 16'h0000);
            for (int j = 0; j < 4; j++) send_nib(4'h0);
            end_frame();
            chk($sformatf("tbl%0d_err_pulse", i), 32'(err_cycles - r0), 32'd1);
            chk($sformatf("tbl%0d_no_drive", i), 32'(oe_cycles - e0), 32'd0);
          end
        endcase
      end

      // Reset while driving read data
      begin_frame();
      hdr(8'h03, 16'h0010);
      send_byte(8'h00);
      recv_nib(q, e);
      chk("midrst_first_nib", 32'(q), 32'hA);
      chk("midrst_busy_pre", 32'(BUSY), 32'h1);
      RES = 1'b1;
      clks(1);
      chk("midrst_sio_e", 32'(QSPI_SIO_E), 32'h0);
      chk("midrst_sio_o", 32'(QSPI_SIO_O), 32'h0);
      chk("midrst_busy",  32'(BUSY),       32'h0);
      RES = 1'b0;
      end_frame();
      do_read(16'h0010, 1, got, oe_ok);
      chk("midrst_reread", got, 32'h0000_00A5);

      // Random traffic against the byte-array model
      foreach (vld[i]) vld[i] = 1'b0;
      wq.delete();
      for (int t = 0; t < 10; t++) begin
        a = 16'($urandom_range(0, 65535));
        n = $urandom_range(1, 4);
        d = $urandom;
        do_write(a, n, d);
        for (int i = 0; i < n; i++) begin
          ai = a + 16'(i);
          mdl[ai[11:0]] = d[8*(n-1-i) +: 8];
          vld[ai[11:0]] = 1'b1;
        end
        wq.push_back(a);
      end
      for (int t = 0; t < 10; t++) begin
        a = wq[$urandom_range(0, wq.size() - 1)] + 16'($urandom_range(0, 2));
        n = $urandom_range(1, 3);
        k = 0;
        exp = '0;
        for (int i = 0; i < n; i++) begin
          ai = a + 16'(i);
          if (vld[ai[11:0]] && k == i) begin
            k++;
            exp = {exp[23:0], mdl[ai[11:0]]};
          end
        end
        if (k == 0) begin
          a = wq[0];
          k = 1;
          exp = 32'(mdl[a[11:0]]);
        end
        do_read(a, k, got, oe_ok);
        chk($sformatf("rnd%0d_data@%04h", t, a), got, exp);
        chk($sformatf("rnd%0d_oe", t), 32'(oe_ok), 32'h1);
      end
    end

    chk("total_cmd_err_pulses", 32'(err_cycles), 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
